// File: rtl/wb_mon_pkg.sv
// Shared types for the Wishbone pipelined pass-through monitor:
// FSM state encoding and bit positions of the violation vector.
package wb_mon_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } mon_state_e;

    localparam int V_REQ  = 0;
    localparam int V_RSP  = 1;
    localparam int V_RDAT = 2;
    localparam int V_OVF  = 3;
    localparam int V_UNF  = 4;
    localparam int N_VIOL = 5;

endpackage

// File: rtl/wb_mon_fifo.sv
// DEPTH x 1-bit FIFO holding the write-enable of each outstanding access.
// flush_i empties it immediately; a pop of an empty FIFO is ignored.
module wb_mon_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   async_rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   din_i,
    output logic                   dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/wb_pipe_pass_monitor.sv
// Passive monitor comparing the initiator and target sides of a Wishbone
// pipelined pass-through; raises sticky flags and a saturating event count.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RESET  | one cycle after any reset; tracking and checks suppressed
// ST_IDLE   | no accesses outstanding
// ST_ACTIVE | at least one access issued and not yet completed/flushed
module wb_pipe_pass_monitor
    import wb_mon_pkg::*;
#(
    parameter int ADR_WIDTH  = 16,
    parameter int DAT_WIDTH  = 16,
    parameter int SEL_WIDTH  = 2,
    parameter int TGA_WIDTH  = 1,
    parameter int TGC_WIDTH  = 1,
    parameter int TGRD_WIDTH = 1,
    parameter int TGWD_WIDTH = 1,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                   clk_i,
    input  logic                   async_rst_i,
    input  logic                   sync_rst_i,
    input  logic                   mon_en_i,
    input  logic                   clr_i,
    input  logic                   itr_cyc_i,
    input  logic                   itr_stb_i,
    input  logic                   itr_we_i,
    input  logic                   itr_lock_i,
    input  logic [SEL_WIDTH-1:0]   itr_sel_i,
    input  logic [ADR_WIDTH-1:0]   itr_adr_i,
    input  logic [DAT_WIDTH-1:0]   itr_dat_i,
    input  logic [TGA_WIDTH-1:0]   itr_tga_i,
    input  logic [TGC_WIDTH-1:0]   itr_tgc_i,
    input  logic [TGWD_WIDTH-1:0]  itr_tgd_i,
    input  logic                   itr_ack_o,
    input  logic                   itr_err_o,
    input  logic                   itr_rty_o,
    input  logic                   itr_stall_o,
    input  logic [DAT_WIDTH-1:0]   itr_dat_o,
    input  logic [TGRD_WIDTH-1:0]  itr_tgd_o,
    input  logic                   tgt_cyc_o,
    input  logic                   tgt_stb_o,
    input  logic                   tgt_we_o,
    input  logic                   tgt_lock_o,
    input  logic [SEL_WIDTH-1:0]   tgt_sel_o,
    input  logic [ADR_WIDTH-1:0]   tgt_adr_o,
    input  logic [DAT_WIDTH-1:0]   tgt_dat_o,
    input  logic [TGA_WIDTH-1:0]   tgt_tga_o,
    input  logic [TGC_WIDTH-1:0]   tgt_tgc_o,
    input  logic [TGWD_WIDTH-1:0]  tgt_tgd_o,
    input  logic                   tgt_ack_i,
    input  logic                   tgt_err_i,
    input  logic                   tgt_rty_i,
    input  logic                   tgt_stall_i,
    input  logic [DAT_WIDTH-1:0]   tgt_dat_i,
    input  logic [TGRD_WIDTH-1:0]  tgt_tgd_i,
    output logic                   err_req_o,
    output logic                   err_rsp_o,
    output logic                   err_rdat_o,
    output logic                   err_ovf_o,
    output logic                   err_unf_o,
    output logic [CNT_WIDTH-1:0]   mismatch_cnt_o,
    output logic [$clog2(DEPTH):0] outstanding_o,
    output logic                   busy_o
);
    mon_state_e              state_q;
    mon_state_e              state_d;
    logic                    live;
    logic                    chk_en;
    logic                    req;
    logic                    rsp;
    logic                    push;
    logic                    pop;
    logic                    flush;
    logic                    full;
    logic                    empty;
    logic                    head_we;
    logic [$clog2(DEPTH):0]  count;
    logic [N_VIOL-1:0]       viol;
    logic [N_VIOL-1:0]       flags_q;
    logic [CNT_WIDTH-1:0]    cnt_q;

    assign req = mon_en_i & itr_cyc_i & itr_stb_i & ~itr_stall_o;
    assign rsp = itr_ack_o | itr_err_o | itr_rty_o;

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q <= ST_RESET;
        end else if (sync_rst_i) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_IDLE;
            ST_IDLE:   if (req) state_d = ST_ACTIVE;
            ST_ACTIVE: if (!itr_cyc_i || (empty && !req)) state_d = ST_IDLE;
            default:   state_d = ST_RESET;
        endcase
    end

    always_comb begin
        live   = (state_q != ST_RESET) && !sync_rst_i;
        chk_en = live && mon_en_i;
    end

    // Dropping CYC abandons every outstanding access; this is legal, not a violation.
    assign flush = sync_rst_i | (live & ~itr_cyc_i);
    assign pop   = live & rsp & ~empty;
    assign push  = live & req;

    wb_mon_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .async_rst_i (async_rst_i),
        .flush_i     (flush),
        .push_i      (push),
        .pop_i       (pop),
        .din_i       (itr_we_i),
        .dout_o      (head_we),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count)
    );

    always_comb begin
        viol = '0;
        if (chk_en) begin
            if ((tgt_cyc_o & tgt_stb_o) != (itr_cyc_i & itr_stb_i)) viol[V_REQ] = 1'b1;
            if (req && ((tgt_we_o != itr_we_i) || (tgt_lock_o != itr_lock_i) ||
                        (tgt_sel_o != itr_sel_i) || (tgt_adr_o != itr_adr_i) ||
                        (tgt_tga_o != itr_tga_i) || (tgt_tgc_o != itr_tgc_i) ||
                        (tgt_stall_i != itr_stall_o))) viol[V_REQ] = 1'b1;
            if (req && itr_we_i && ((tgt_dat_o != itr_dat_i) || (tgt_tgd_o != itr_tgd_i)))
                viol[V_REQ] = 1'b1;
            if (!empty && ({itr_ack_o, itr_err_o, itr_rty_o} != {tgt_ack_i, tgt_err_i, tgt_rty_i}))
                viol[V_RSP] = 1'b1;
            if (itr_ack_o && !empty && !head_we &&
                ((itr_dat_o != tgt_dat_i) || (itr_tgd_o != tgt_tgd_i))) viol[V_RDAT] = 1'b1;
            if (req && full && !rsp) viol[V_OVF] = 1'b1;
            if (rsp && empty) viol[V_UNF] = 1'b1;
        end
    end

    // A violation in the clearing cycle survives the clear.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            flags_q <= '0;
            cnt_q   <= '0;
        end else if (sync_rst_i) begin
            flags_q <= '0;
            cnt_q   <= '0;
        end else if (clr_i) begin
            flags_q <= viol;
            cnt_q   <= CNT_WIDTH'(|viol);
        end else begin
            flags_q <= flags_q | viol;
            if ((|viol) && (cnt_q != '1)) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign err_req_o      = flags_q[V_REQ];
    assign err_rsp_o      = flags_q[V_RSP];
    assign err_rdat_o     = flags_q[V_RDAT];
    assign err_ovf_o      = flags_q[V_OVF];
    assign err_unf_o      = flags_q[V_UNF];
    assign mismatch_cnt_o = cnt_q;
    assign outstanding_o  = count;
    assign busy_o         = (count != '0);

endmodule

// File: doc/wb_pipe_pass_monitor.md
WB_PIPE_PASS_MONITOR -- requirements
Module: wb_pipe_pass_monitor

Interface
REQ-001 Parameters: ADR_WIDTH 16, address width; DAT_WIDTH 16, data width; SEL_WIDTH 2, select width.
REQ-002 Parameters: TGA_WIDTH 1, TGC_WIDTH 1, TGRD_WIDTH 1, TGWD_WIDTH 1, tag widths.
REQ-003 Parameters: DEPTH 4, maximum outstanding accesses (power of two, >=2); CNT_WIDTH 8, mismatch counter width.
REQ-004 clk_i  input  1  clock; async_rst_i  input  1  reset, asynchronous, active-high.
REQ-005 sync_rst_i  input  1  synchronous reset, active-high.
REQ-006 mon_en_i  input  1  monitor enable; clr_i  input  1  clears sticky flags and counter.
REQ-007 itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i  input  1 each  initiator request controls.
REQ-008 itr_sel_i, itr_adr_i, itr_dat_i, itr_tga_i, itr_tgc_i, itr_tgd_i  input  parameter widths  initiator request fields.
REQ-009 itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o  input  1 each; itr_dat_o, itr_tgd_o  input  DAT/TGRD_WIDTH  initiator-side responses.
REQ-010 tgt_* counterparts of REQ-007..009 (cyc_o..tgd_o, ack_i..tgd_i)  input  same widths  target side.
REQ-011 err_req_o, err_rsp_o, err_rdat_o, err_ovf_o, err_unf_o  output  1 each  sticky violation flags.
REQ-012 mismatch_cnt_o  output  CNT_WIDTH  saturating violation-event count.
REQ-013 outstanding_o  output  $clog2(DEPTH)+1  accesses in flight; busy_o  output  1  outstanding_o != 0.

Function
REQ-014 req = mon_en_i & itr_cyc_i & itr_stb_i & ~itr_stall_o; rsp = itr_ack_o | itr_err_o | itr_rty_o.
REQ-015 FSM states RESET, IDLE, ACTIVE; RESET->IDLE unconditionally; IDLE->ACTIVE on req; ACTIVE->IDLE when count reaches 0 with no req.
REQ-016 Each req pushes itr_we_i into a DEPTH-entry FIFO; each rsp with count>0 pops head; simultaneous push/pop keeps count, order preserved.
REQ-017 req with count==DEPTH and no same-cycle rsp: not recorded, err_ovf_o set.
REQ-018 rsp with count==0: err_unf_o set, no pop, pointers unchanged.
REQ-019 itr_cyc_i low while count>0: FIFO flushed, count 0, FSM to IDLE; no flag.
REQ-020 Outside RESET with mon_en_i: (tgt_cyc_o&tgt_stb_o) != (itr_cyc_i&itr_stb_i) sets err_req_o.
REQ-021 On req: mismatch of we, lock, sel, adr, tga, tgc, or itr_stall_o vs tgt_stall_i sets err_req_o; on write req also dat, tgd.
REQ-022 While count>0: ack/err/rty mismatch between initiator and target sets err_rsp_o.
REQ-023 On itr_ack_o with head entry read: itr_dat_o/itr_tgd_o vs tgt_dat_i/tgt_tgd_i mismatch sets err_rdat_o.
REQ-024 Flags registered: set at clock edge ending violating cycle, visible next cycle; remain set until clr_i or reset.
REQ-025 mismatch_cnt_o increments by 1 per cycle with any violation, saturates at all-ones, never wraps.
REQ-026 clr_i clears flags and counter; violation in same cycle as clr_i wins (flag set, counter = 1).
REQ-027 All checks suppressed while sync_rst_i or async_rst_i asserted or FSM in RESET.

Reset
REQ-028 async_rst_i or sync_rst_i: FSM RESET, FIFO pointers and count 0, all flags 0, mismatch_cnt_o 0, busy_o 0.
REQ-029 Reset mid-operation discards all outstanding entries; no flag raised by the abort.

Structure
REQ-030 Package wb_mon_pkg holds FSM state enum (RESET/IDLE/ACTIVE) and violation index constants.
REQ-031 One sub-module wb_mon_fifo (DEPTH x 1 bit, push/pop/flush, full/empty/count); remainder in top.

Verification
REQ-032 Three back-to-back reads adr 0x10/0x12/0x14, acks cycles 3-5, data pass through -> outstanding 1,2,3,2,1,0; no flags.
REQ-033 Target returns read data 0xBEEF vs initiator 0xBEEE on 2nd ack -> err_rdat_o=1 next cycle, mismatch_cnt_o=1.
REQ-034 DEPTH=4, five unstalled requests with no ack -> err_ovf_o=1, outstanding_o=4.
REQ-035 Ack with outstanding 0 -> err_unf_o=1; then clr_i -> all flags 0, counter 0.
REQ-036 Two reads in flight, itr_cyc_i dropped -> outstanding_o=0, busy_o=0, no flags.
REQ-037 300 violating cycles with CNT_WIDTH=8 -> mismatch_cnt_o=255; async_rst_i pulse mid-burst -> all outputs 0.
